// File: rtl/pong_input_conditioner_if.sv
// Board-side bundle for the pong input conditioner: raw key/switch inputs and conditioned paddle/serve outputs.
interface pong_input_conditioner_if;
  logic       serve_raw_n;
  logic [3:0] sw_raw;
  logic       left_up;
  logic       left_down;
  logic       right_up;
  logic       right_down;
  logic       serve;

  modport master (
    output serve_raw_n,
    output sw_raw,
    input  left_up,
    input  left_down,
    input  right_up,
    input  right_down,
    input  serve
  );

  modport slave (
    input  serve_raw_n,
    input  sw_raw,
    output left_up,
    output left_down,
    output right_up,
    output right_down,
    output serve
  );
endinterface

// File: rtl/pong_input_conditioner.sv
// Synchronises and debounces the serve key and four paddle switches, masks up+down conflicts, pulses serve.
// Optional build macro PONG_SERVE_AUTOREPEAT_EN adds periodic serve pulses while the key stays held.
module pong_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  pong_input_conditioner_if.slave  bus
);

  localparam int unsigned     N_IN      = 5;
  localparam int unsigned     SERVE_IDX = 4;
  localparam int unsigned     CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  // Raw polarity is kept end to end: switches idle low, the serve key idles high.
  localparam logic [N_IN-1:0] INACTIVE  = 5'b1_0000;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_t;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  // Returns {up, down} with both forced low when the paddle is commanded both ways.
  function automatic logic [1:0] paddle_mask(input logic up, input logic down);
    logic [1:0] res;
    res = {up & ~down, down & ~up};
    return res;
  endfunction

  logic [N_IN-1:0]        raw_s;
  logic [N_IN-1:0]        sample_s;
  logic [SYNC_STAGES-1:0] sync_r     [N_IN];
  db_state_t              state_r    [N_IN];
  db_state_t              state_nx_s [N_IN];
  logic [CNT_W-1:0]       cnt_r      [N_IN];
  logic [CNT_W-1:0]       cnt_nx_s   [N_IN];
  logic [N_IN-1:0]        acc_r;
  logic [N_IN-1:0]        acc_nx_s;
  logic [1:0]             left_nx_s;
  logic [1:0]             right_nx_s;
  logic                   pressed_r_s;
  logic                   pressed_nx_s;
  logic                   press_rise_s;
  logic                   serve_fire_s;
  logic                   left_up_r;
  logic                   left_down_r;
  logic                   right_up_r;
  logic                   right_down_r;
  logic                   serve_r;

  assign raw_s = {bus.serve_raw_n, bus.sw_raw};

  // Per-input synchroniser chains, preset to each input's idle level.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_IN; i++) begin
        sync_r[i] <= {SYNC_STAGES{INACTIVE[i]}};
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], raw_s[i]};
      end
    end
  end

  // Last synchroniser stage is the sample seen by each debouncer.
  always_comb begin
    sample_s = '0;
    for (int i = 0; i < N_IN; i++) begin
      sample_s[i] = sync_r[i][SYNC_STAGES-1];
    end
  end

  // Debouncer next state: a change must hold for DEBOUNCE_CYCLES uninterrupted samples.
  always_comb begin
    acc_nx_s = acc_r;
    for (int i = 0; i < N_IN; i++) begin
      state_nx_s[i] = state_r[i];
      cnt_nx_s[i]   = cnt_r[i];
      case (state_r[i])
        ST_STABLE: begin
          if (sample_s[i] != acc_r[i]) begin
            state_nx_s[i] = ST_PENDING;
            cnt_nx_s[i]   = CNT_ONE;
          end else begin
            cnt_nx_s[i]   = '0;
          end
        end
        ST_PENDING: begin
          if (sample_s[i] == acc_r[i]) begin
            state_nx_s[i] = ST_STABLE;
            cnt_nx_s[i]   = '0;
          end else if (cnt_r[i] >= CNT_LAST) begin
            acc_nx_s[i]   = sample_s[i];
            state_nx_s[i] = ST_STABLE;
            cnt_nx_s[i]   = '0;
          end else begin
            cnt_nx_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          state_nx_s[i] = ST_STABLE;
          cnt_nx_s[i]   = '0;
        end
      endcase
    end
  end

  // Outputs are derived from the next accepted values so they move on the acceptance edge.
  always_comb begin
    left_nx_s    = paddle_mask(acc_nx_s[0], acc_nx_s[1]);
    right_nx_s   = paddle_mask(acc_nx_s[2], acc_nx_s[3]);
    pressed_r_s  = ~acc_r[SERVE_IDX];
    pressed_nx_s = ~acc_nx_s[SERVE_IDX];
    press_rise_s = pressed_nx_s & ~pressed_r_s;
  end

`ifdef PONG_SERVE_AUTOREPEAT_EN
  localparam int unsigned      RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt_r;
  logic [RPT_W-1:0] rpt_nx_s;
  logic             rpt_fire_s;

  // Repeat timer runs only while the accepted key stays pressed across an edge.
  always_comb begin
    rpt_nx_s   = '0;
    rpt_fire_s = 1'b0;
    if (pressed_r_s && pressed_nx_s) begin
      if (rpt_cnt_r >= RPT_LAST) begin
        rpt_fire_s = 1'b1;
        rpt_nx_s   = '0;
      end else begin
        rpt_nx_s   = rpt_cnt_r + RPT_ONE;
      end
    end else begin
      rpt_nx_s = '0;
    end
  end

  // Repeat counter register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_r <= '0;
    end else begin
      rpt_cnt_r <= rpt_nx_s;
    end
  end

  assign serve_fire_s = press_rise_s | rpt_fire_s;
`else
  assign serve_fire_s = press_rise_s;
`endif

  // Debouncer state, accepted levels and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_IN; i++) begin
        state_r[i] <= ST_STABLE;
        cnt_r[i]   <= '0;
      end
      acc_r        <= INACTIVE;
      left_up_r    <= 1'b0;
      left_down_r  <= 1'b0;
      right_up_r   <= 1'b0;
      right_down_r <= 1'b0;
      serve_r      <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        state_r[i] <= state_nx_s[i];
        cnt_r[i]   <= cnt_nx_s[i];
      end
      acc_r        <= acc_nx_s;
      left_up_r    <= left_nx_s[1];
      left_down_r  <= left_nx_s[0];
      right_up_r   <= right_nx_s[1];
      right_down_r <= right_nx_s[0];
      serve_r      <= serve_fire_s;
    end
  end

  assign bus.left_up    = left_up_r;
  assign bus.left_down  = left_down_r;
  assign bus.right_up   = right_up_r;
  assign bus.right_down = right_down_r;
  assign bus.serve      = serve_r;

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Directed, table-driven bench for pong_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10).
module tb_pong_input_conditioner;

  typedef struct {
    logic [3:0] sw;
    logic       sn;
    int         edges;
    logic [4:0] exp;   // {left_up, left_down, right_up, right_down, serve}
  } vec_t;

  localparam int NV = 23;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t tbl [NV];

  pong_input_conditioner_if bus();

  pong_input_conditioner #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(10)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {bus.left_up, bus.left_down, bus.right_up, bus.right_down, bus.serve};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    int pulses;
    int exp_rep;

    tbl = '{
      '{4'h1, 1'b1, 5, 5'b00000},  // left_up rise, one edge early
      '{4'h1, 1'b1, 1, 5'b10000},  // accepted on 6th edge
      '{4'h0, 1'b1, 5, 5'b10000},
      '{4'h0, 1'b1, 1, 5'b00000},  // fall accepted on 6th edge
      '{4'h1, 1'b1, 3, 5'b00000},  // bounce: high 3
      '{4'h0, 1'b1, 1, 5'b00000},  // low 1
      '{4'h1, 1'b1, 5, 5'b00000},  // high again, 5 edges
      '{4'h1, 1'b1, 1, 5'b10000},  // 6 edges after last rise
      '{4'h0, 1'b1, 8, 5'b00000},
      '{4'h1, 1'b1, 3, 5'b00000},  // isolated 3-cycle pulse
      '{4'h0, 1'b1, 8, 5'b00000},  // never accepted
      '{4'h5, 1'b1, 5, 5'b00000},  // left_up + right_up together
      '{4'h5, 1'b1, 1, 5'b10100},
      '{4'h7, 1'b1, 5, 5'b10100},  // add left_down
      '{4'h7, 1'b1, 1, 5'b00100},  // left masked, right untouched
      '{4'h6, 1'b1, 5, 5'b00100},  // drop left_up
      '{4'h6, 1'b1, 1, 5'b01100},
      '{4'hE, 1'b1, 5, 5'b01100},  // add right_down
      '{4'hE, 1'b1, 1, 5'b01000},  // right masked, left untouched
      '{4'h0, 1'b1, 6, 5'b00000},
      '{4'h0, 1'b0, 5, 5'b00000},  // serve press, one edge early
      '{4'h0, 1'b0, 1, 5'b00001},  // serve pulse
      '{4'h0, 1'b0, 1, 5'b00000}   // one cycle only
    };

    // Reset with every input active.
    bus.sw_raw = 4'hF;
    bus.serve_raw_n = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    check("reset_state", outs(), 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("held_rst_e%0d", e), outs(), 5'b00000);
    end
    step();
    check("held_rst_e6", outs(), 5'b00001);
    step();
    check("held_rst_e7", outs(), 5'b00000);

    bus.sw_raw = 4'h0;
    bus.serve_raw_n = 1'b1;
    repeat (8) step();
    check("idle", outs(), 5'b00000);

    for (int i = 0; i < NV; i++) begin
      bus.sw_raw = tbl[i].sw;
      bus.serve_raw_n = tbl[i].sn;
      repeat (tbl[i].edges) step();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Keep serve held to edge 40 after the press, then release.
`ifdef PONG_SERVE_AUTOREPEAT_EN
    exp_rep = 3;
`else
    exp_rep = 0;
`endif
    pulses = 0;
    for (int e = 8; e <= 40; e++) begin
      step();
      if (bus.serve === 1'b1) pulses++;
    end
    check_int("serve_hold_pulses", pulses, exp_rep);
    bus.serve_raw_n = 1'b1;
    pulses = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (bus.serve === 1'b1) pulses++;
    end
    check_int("serve_release_pulses", pulses, 0);
    check("after_release", outs(), 5'b00000);

    // Reset while left_up is mid-pending.
    bus.sw_raw = 4'h4;
    repeat (8) step();
    check("pre_rst_right", outs(), 5'b00100);
    bus.sw_raw = 4'h5;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    check("async_rst", outs(), 5'b00000);
    repeat (2) step();
    check("in_rst", outs(), 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step();
    check("requal_e5", outs(), 5'b00000);
    step();
    check("requal_e6", outs(), 5'b10100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
